sdspi_llbyte: RTL and testbench



---
 rtl/sdspi_pkg.sv | 13 +
 rtl/sdspi_llbyte_if.sv | 22 ++
 rtl/sdspi_sckdiv.sv | 28 ++
 rtl/sdspi_llbyte.sv | 127 ++++++++++++
 tb/tb_sdspi_llbyte.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdspi_pkg.sv
// Shared types and constants for the SD-card SPI byte engine.
package sdspi_pkg;

    typedef enum logic [1:0] {
        SDSPI_IDLE = 2'd0,
        SDSPI_LOW  = 2'd1,
        SDSPI_HIGH = 2'd2
    } sdspi_state_e;

    localparam int   SDSPI_MIN_HALF  = 1;
    localparam logic SDSPI_IDLE_MOSI = 1'b1;

endpackage

// File: rtl/sdspi_llbyte_if.sv
// Upstream byte handshake between the SD command sequencer and the SPI byte engine.
interface sdspi_llbyte_if #(
    parameter int SPDBITS = 7
);
    logic [SPDBITS-1:0] i_speed;
    logic               i_cs;
    logic               i_stb;
    logic [7:0]         i_byte;
    logic               o_busy;
    logic               o_stb;
    logic [7:0]         o_byte;

    modport master (
        output i_speed, i_cs, i_stb, i_byte,
        input  o_busy, o_stb, o_byte
    );

    modport slave (
        input  i_speed, i_cs, i_stb, i_byte,
        output o_busy, o_stb, o_byte
    );
endinterface

// File: rtl/sdspi_sckdiv.sv
// SCK half-period down-counter: reloads on each phase entry, ticks on the last cycle of the phase.
module sdspi_sckdiv
    import sdspi_pkg::*;
#(
    parameter int SPDBITS = 7
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_load,
    input  logic [SPDBITS-1:0] i_half,
    output logic               o_tick
);
    localparam logic [SPDBITS-1:0] TERM = SPDBITS'(SDSPI_MIN_HALF);

    logic [SPDBITS-1:0] cnt;

    // Loaded with H, so a phase lasts H cycles: H, H-1, ..., 1.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            cnt <= TERM;
        else if (i_load)
            cnt <= i_half;
        else if (cnt > TERM)
            cnt <= cnt - SPDBITS'(1);
    end

    assign o_tick = (cnt == TERM);
endmodule

// File: rtl/sdspi_llbyte.sv
// SPI mode-0 byte engine: shifts one byte out MSB-first on MOSI while capturing MISO.
module sdspi_llbyte
    import sdspi_pkg::*;
#(
    parameter int SPDBITS = 7
) (
    input  logic           i_clk,
    input  logic           i_reset_n,
    sdspi_llbyte_if.slave  bus,
    output logic           o_cs_n,
    output logic           o_sck,
    output logic           o_mosi,
    input  logic           i_miso
);
    localparam logic [SPDBITS-1:0] MIN_HALF = SPDBITS'(SDSPI_MIN_HALF);

    sdspi_state_e       state, state_d;
    logic [SPDBITS-1:0] half_q, half_d, div_half;
    logic [7:0]         tx_sr, tx_d, rx_sr, rx_d, byte_q, byte_d;
    logic [2:0]         bit_cnt, bit_d;
    logic               busy_q, busy_d, stb_q, stb_d;
    logic               cs_n_q, cs_n_d, sck_q, sck_d, mosi_q, mosi_d;
    logic               div_load, tick;

    sdspi_sckdiv #(.SPDBITS(SPDBITS)) u_sckdiv (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (div_load),
        .i_half    (div_half),
        .o_tick    (tick)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= SDSPI_IDLE;
            half_q  <= MIN_HALF;
            tx_sr   <= 8'h00;
            rx_sr   <= 8'h00;
            byte_q  <= 8'hff;
            bit_cnt <= 3'd0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            cs_n_q  <= 1'b1;
            sck_q   <= 1'b0;
            mosi_q  <= SDSPI_IDLE_MOSI;
        end else begin
            state   <= state_d;
            half_q  <= half_d;
            tx_sr   <= tx_d;
            rx_sr   <= rx_d;
            byte_q  <= byte_d;
            bit_cnt <= bit_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            cs_n_q  <= cs_n_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
        end
    end

    always_comb begin
        state_d  = state;
        half_d   = half_q;
        tx_d     = tx_sr;
        rx_d     = rx_sr;
        byte_d   = byte_q;
        bit_d    = bit_cnt;
        busy_d   = busy_q;
        stb_d    = 1'b0;
        cs_n_d   = cs_n_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        div_load = 1'b0;
        div_half = half_q;

        case (state)
            SDSPI_IDLE: begin
                // Chip select only moves between bytes, never mid-transfer.
                cs_n_d = !bus.i_cs;
                if (bus.i_stb) begin
                    half_d   = (bus.i_speed < MIN_HALF) ? MIN_HALF : bus.i_speed;
                    tx_d     = bus.i_byte;
                    bit_d    = 3'd0;
                    mosi_d   = bus.i_byte[7];
                    busy_d   = 1'b1;
                    state_d  = SDSPI_LOW;
                    div_load = 1'b1;
                    div_half = half_d;
                end
            end
            SDSPI_LOW: begin
                if (tick) begin
                    sck_d    = 1'b1;
                    state_d  = SDSPI_HIGH;
                    div_load = 1'b1;
                end
            end
            SDSPI_HIGH: begin
                if (tick) begin
                    sck_d    = 1'b0;
                    rx_d     = {rx_sr[6:0], i_miso};
                    bit_d    = bit_cnt + 3'd1;
                    div_load = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_d = SDSPI_IDLE;
                        busy_d  = 1'b0;
                        stb_d   = 1'b1;
                        byte_d  = rx_d;
                        mosi_d  = SDSPI_IDLE_MOSI;
                    end else begin
                        tx_d    = {tx_sr[6:0], 1'b0};
                        mosi_d  = tx_sr[6];
                        state_d = SDSPI_LOW;
                    end
                end
            end
            default: state_d = SDSPI_IDLE;
        endcase
    end

    assign bus.o_busy = busy_q;
    assign bus.o_stb  = stb_q;
    assign bus.o_byte = byte_q;
    assign o_cs_n     = cs_n_q;
    assign o_sck      = sck_q;
    assign o_mosi     = mosi_q;
endmodule

// File: tb/tb_sdspi_llbyte.sv
// Bench for sdspi_llbyte: vector table, hand-written corner sequences and random bytes vs a timing model.
module tb_sdspi_llbyte;

    typedef struct {
        logic [6:0] spd;
        logic [7:0] tx;
        logic [7:0] rx;
        logic       cs;
        int         mid_at;
        logic [6:0] mid_spd;
        logic       mid_cs;
        int         exp_lat;
        logic       exp_csn_busy;
        logic       exp_csn_after;
    } vec_t;

    typedef struct {
        int         lat;
        logic [7:0] got;
        logic [7:0] mbits;
        int         pulses;
        int         phase_bad;
        int         busy_bad;
        int         mosi_bad;
        int         csn_bad;
        logic       stb_after;
        logic       csn_after;
    } res_t;

    logic i_clk, i_reset_n, o_cs_n, o_sck, o_mosi, i_miso;
    logic [7:0] miso_pat;
    logic [3:0] idx;
    logic       sck_prev;
    int         n_cmp, n_bad;

    sdspi_llbyte_if #(.SPDBITS(7)) bus ();

    sdspi_llbyte #(.SPDBITS(7)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus),
        .o_cs_n    (o_cs_n),
        .o_sck     (o_sck),
        .o_mosi    (o_mosi),
        .i_miso    (i_miso)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Card model: presents the next MISO bit after each falling SCK edge.
    assign i_miso = idx[3] ? 1'b1 : miso_pat[3'd7 - idx[2:0]];
    always @(negedge i_clk) begin
        if (!i_reset_n || !bus.o_busy)
            idx <= 4'd0;
        else if (sck_prev && !o_sck)
            idx <= idx + 4'd1;
        sck_prev <= o_sck;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int model_lat(input logic [6:0] spd);
        return 16 * ((spd == 7'd0) ? 1 : int'(spd)) + 1;
    endfunction

    task automatic run_byte(input vec_t v, output res_t r);
        int   h, run;
        logic psck, pmosi;
        h = (v.spd == 7'd0) ? 1 : int'(v.spd);
        r.lat = -1; r.got = 8'h00; r.mbits = 8'h00; r.pulses = 0;
        r.phase_bad = 0; r.busy_bad = 0; r.mosi_bad = 0; r.csn_bad = 0;
        @(negedge i_clk);
        bus.i_speed = v.spd; bus.i_cs = v.cs; bus.i_byte = v.tx;
        miso_pat = v.rx; bus.i_stb = 1'b1;
        @(posedge i_clk);
        psck = 1'b0; pmosi = 1'b1; run = 0;
        for (int n = 1; n <= 4000; n++) begin
            @(negedge i_clk);
            if (n == 1) bus.i_stb = 1'b0;
            if (n == v.mid_at) begin
                bus.i_speed = v.mid_spd;
                bus.i_cs = v.mid_cs;
            end
            if (o_sck != psck) begin
                if (run != h) r.phase_bad++;
                run = 1;
                if (o_sck) begin
                    r.mbits = {r.mbits[6:0], o_mosi};
                    r.pulses++;
                end
            end else
                run++;
            if (n > 1 && o_mosi != pmosi && !(psck && !o_sck)) r.mosi_bad++;
            if (o_cs_n != v.exp_csn_busy) r.csn_bad++;
            psck = o_sck; pmosi = o_mosi;
            if (bus.o_stb) begin
                r.lat = n;
                r.got = bus.o_byte;
                if (bus.o_busy || o_sck || !o_mosi) r.busy_bad++;
                break;
            end
            if (!bus.o_busy) r.busy_bad++;
        end
        @(negedge i_clk);
        r.stb_after = bus.o_stb;
        r.csn_after = o_cs_n;
    endtask

    task automatic check_res(input string tag, input vec_t v, input res_t r);
        chk({tag, ".lat"},       r.lat,            v.exp_lat);
        chk({tag, ".rx"},        int'(r.got),      int'(v.rx));
        chk({tag, ".mosi"},      int'(r.mbits),    int'(v.tx));
        chk({tag, ".pulses"},    r.pulses,         8);
        chk({tag, ".phase"},     r.phase_bad,      0);
        chk({tag, ".busy"},      r.busy_bad,       0);
        chk({tag, ".mosi_hold"}, r.mosi_bad,       0);
        chk({tag, ".csn_busy"},  r.csn_bad,        0);
        chk({tag, ".stb_1cyc"},  int'(r.stb_after), 0);
        chk({tag, ".csn_after"}, int'(r.csn_after), int'(v.exp_csn_after));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".busy"}, int'(bus.o_busy), 0);
        chk({tag, ".stb"},  int'(bus.o_stb),  0);
        chk({tag, ".byte"}, int'(bus.o_byte), 8'hff);
        chk({tag, ".cs_n"}, int'(o_cs_n),     1);
        chk({tag, ".sck"},  int'(o_sck),      0);
        chk({tag, ".mosi"}, int'(o_mosi),     1);
    endtask

    vec_t tbl[7];
    vec_t v;
    res_t r;
    int   stb_seen, pulses_total, first_stb, second_stb, cyc;
    logic [7:0] b1, b2;

    initial begin
        n_cmp = 0; n_bad = 0;
        i_reset_n = 1'b0;
        bus.i_stb = 1'b0; bus.i_cs = 1'b0; bus.i_byte = 8'h00; bus.i_speed = 7'd1;
        miso_pat = 8'hff;

        //        spd    tx     rx     cs  mid mspd   mcs  lat   csnB  csnA
        tbl[0] = '{7'd1,   8'hA5, 8'h3C, 1'b1, 0,  7'd1, 1'b1, 17,   1'b0, 1'b0};
        tbl[1] = '{7'd0,   8'hA5, 8'h3C, 1'b1, 0,  7'd0, 1'b1, 17,   1'b0, 1'b0};
        tbl[2] = '{7'd4,   8'h40, 8'hC3, 1'b0, 0,  7'd4, 1'b0, 65,   1'b1, 1'b1};
        tbl[3] = '{7'd2,   8'h5A, 8'h96, 1'b0, 13, 7'd2, 1'b1, 33,   1'b1, 1'b0};
        tbl[4] = '{7'd3,   8'h00, 8'hFF, 1'b1, 20, 7'd7, 1'b1, 49,   1'b0, 1'b0};
        tbl[5] = '{7'd7,   8'hFF, 8'h00, 1'b0, 30, 7'd0, 1'b0, 113,  1'b1, 1'b1};
        tbl[6] = '{7'd127, 8'h81, 8'h18, 1'b0, 0,  7'd1, 1'b0, 2033, 1'b1, 1'b1};

        repeat (3) @(negedge i_clk);
        chk_reset_vals("in_reset");
        i_reset_n = 1'b1;
        @(negedge i_clk);
        chk_reset_vals("post_reset");

        for (int i = 0; i < 7; i++) begin
            run_byte(tbl[i], r);
            check_res($sformatf("tbl%0d", i), tbl[i], r);
        end

        // Upstream holds stb across two bytes; second accept lands on the first strobe cycle.
        @(negedge i_clk);
        bus.i_speed = 7'd4; bus.i_cs = 1'b0; bus.i_byte = 8'h40; miso_pat = 8'h81; bus.i_stb = 1'b1;
        @(posedge i_clk);
        first_stb = -1; second_stb = -1; b1 = 8'h00; b2 = 8'h00; cyc = 0;
        while (second_stb < 0 && cyc < 400) begin
            @(negedge i_clk);
            cyc++;
            if (bus.o_stb && first_stb < 0) begin
                first_stb = cyc; b1 = bus.o_byte;
                bus.i_byte = 8'h00; miso_pat = 8'h7E;
            end else if (bus.o_stb) begin
                second_stb = cyc; b2 = bus.o_byte;
                bus.i_stb = 1'b0;
            end
        end
        bus.i_stb = 1'b0;
        chk("b2b.first_lat", first_stb, 65);
        chk("b2b.period", second_stb - first_stb, 65);
        chk("b2b.byte1", int'(b1), 8'h81);
        chk("b2b.byte2", int'(b2), 8'h7E);
        @(negedge i_clk);

        // Reset pulse in the middle of bit 5 at H=2.
        @(negedge i_clk);
        bus.i_speed = 7'd2; bus.i_cs = 1'b0; bus.i_byte = 8'hA5; miso_pat = 8'h5A; bus.i_stb = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        bus.i_stb = 1'b0;
        repeat (21) @(negedge i_clk);
        chk("rst.pre_busy", int'(bus.o_busy), 1);
        #2 i_reset_n = 1'b0;
        #1 chk_reset_vals("rst.async");
        stb_seen = 0;
        repeat (3) begin
            @(negedge i_clk);
            if (bus.o_stb) stb_seen++;
        end
        i_reset_n = 1'b1;
        repeat (40) begin
            @(negedge i_clk);
            if (bus.o_stb) stb_seen++;
        end
        chk("rst.no_stb", stb_seen, 0);
        v = '{7'd2, 8'h3C, 8'hC3, 1'b0, 0, 7'd2, 1'b0, 33, 1'b1, 1'b1};
        run_byte(v, r);
        check_res("rst.after", v, r);

        // Init-clock style burst: ten 0xFF bytes with the card deselected.
        pulses_total = 0;
        for (int i = 0; i < 10; i++) begin
            v = '{7'd1, 8'hFF, 8'((i * 37) + 5), 1'b0, 0, 7'd1, 1'b0, 17, 1'b1, 1'b1};
            run_byte(v, r);
            pulses_total += r.pulses;
            check_res($sformatf("ff%0d", i), v, r);
        end
        chk("ff.pulses_total", pulses_total, 80);

        // Random bytes, speeds, and mid-byte speed/cs changes against the timing model.
        for (int i = 0; i < 40; i++) begin
            v.spd = 7'($urandom_range(0, 5));
            v.tx = 8'($urandom);
            v.rx = 8'($urandom);
            v.cs = 1'($urandom);
            v.exp_lat = model_lat(v.spd);
            v.mid_at = $urandom_range(0, v.exp_lat - 1);
            v.mid_spd = 7'($urandom_range(0, 6));
            v.mid_cs = 1'($urandom);
            v.exp_csn_busy = !v.cs;
            v.exp_csn_after = (v.mid_at > 0) ? !v.mid_cs : !v.cs;
            run_byte(v, r);
            check_res($sformatf("rnd%0d", i), v, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
